// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal).
// Moore selects/enables are registered from the next state; PCWrite and illegal also depend on Zero and op.
module multicycle_controller #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         ImmSrc,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    typedef enum logic [STATE_W-1:0] {
        FETCH    = STATE_W'(0),
        DECODE   = STATE_W'(1),
        MEMADR   = STATE_W'(2),
        MEMREAD  = STATE_W'(3),
        MEMWB    = STATE_W'(4),
        MEMWRITE = STATE_W'(5),
        EXECUTER = STATE_W'(6),
        ALUWB    = STATE_W'(7),
        EXECUTEI = STATE_W'(8),
        JAL      = STATE_W'(9),
        BEQ      = STATE_W'(10)
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    state_t     r_state;
    state_t     w_next;
    logic       w_unsupported;

    logic       r_pcupdate;
    logic       r_branch;
    logic       r_adrsrc;
    logic       r_memwrite;
    logic       r_irwrite;
    logic       r_regwrite;
    logic [1:0] r_resultsrc;
    logic [1:0] r_alusrca;
    logic [1:0] r_alusrcb;
    logic [1:0] r_aluop;

    always_comb begin
        w_unsupported = 1'b1;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: w_unsupported = 1'b0;
            default:                                  w_unsupported = 1'b1;
        endcase
    end

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = MEMADR;
                    OP_R:         w_next = EXECUTER;
                    OP_I:         w_next = EXECUTEI;
                    OP_JAL:       w_next = JAL;
                    OP_BEQ:       w_next = BEQ;
                    default:      w_next = FETCH;
                endcase
            end
            MEMADR:   w_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next = MEMWB;
            EXECUTER: w_next = ALUWB;
            EXECUTEI: w_next = ALUWB;
            JAL:      w_next = ALUWB;
            default:  w_next = FETCH;
        endcase
    end

    // Outputs are loaded from the next state so they line up with r_state in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pcupdate  <= 1'b1;
            r_branch    <= 1'b0;
            r_adrsrc    <= 1'b0;
            r_memwrite  <= 1'b0;
            r_irwrite   <= 1'b1;
            r_regwrite  <= 1'b0;
            r_resultsrc <= 2'b10;
            r_alusrca   <= 2'b00;
            r_alusrcb   <= 2'b10;
            r_aluop     <= 2'b00;
        end else begin
            r_state     <= w_next;
            r_pcupdate  <= 1'b0;
            r_branch    <= 1'b0;
            r_adrsrc    <= 1'b0;
            r_memwrite  <= 1'b0;
            r_irwrite   <= 1'b0;
            r_regwrite  <= 1'b0;
            r_resultsrc <= '0;
            r_alusrca   <= '0;
            r_alusrcb   <= '0;
            r_aluop     <= '0;
            case (w_next)
                FETCH: begin
                    r_irwrite   <= 1'b1;
                    r_alusrcb   <= 2'b10;
                    r_resultsrc <= 2'b10;
                    r_pcupdate  <= 1'b1;
                end
                DECODE: begin
                    r_alusrca <= 2'b01;
                    r_alusrcb <= 2'b01;
                end
                MEMADR: begin
                    r_alusrca <= 2'b10;
                    r_alusrcb <= 2'b01;
                end
                MEMREAD: r_adrsrc <= 1'b1;
                MEMWB: begin
                    r_resultsrc <= 2'b01;
                    r_regwrite  <= 1'b1;
                end
                MEMWRITE: begin
                    r_adrsrc   <= 1'b1;
                    r_memwrite <= 1'b1;
                end
                EXECUTER: begin
                    r_alusrca <= 2'b10;
                    r_aluop   <= 2'b10;
                end
                EXECUTEI: begin
                    r_alusrca <= 2'b10;
                    r_alusrcb <= 2'b01;
                    r_aluop   <= 2'b10;
                end
                ALUWB: r_regwrite <= 1'b1;
                JAL: begin
                    r_alusrca  <= 2'b01;
                    r_alusrcb  <= 2'b10;
                    r_pcupdate <= 1'b1;
                end
                BEQ: begin
                    r_alusrca <= 2'b10;
                    r_aluop   <= 2'b01;
                    r_branch  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held, even though FETCH is the reset state.
    assign PCWrite   = rst_n & ((r_branch & Zero) | r_pcupdate);
    assign MemWrite  = rst_n & r_memwrite;
    assign IRWrite   = rst_n & r_irwrite;
    assign RegWrite  = rst_n & r_regwrite;
    assign illegal   = rst_n & (r_state == DECODE) & w_unsupported;
    assign AdrSrc    = r_adrsrc;
    assign ResultSrc = r_resultsrc;
    assign ALUSrcA   = r_alusrca;
    assign ALUSrcB   = r_alusrcb;
    assign ALUOp     = r_aluop;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes per-cycle expectations, a monitor checks at negedge.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1110011;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aop;
        logic [1:0] imm;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = LW;
    logic       Zero = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [3:0] state_dbg;

    exp_t  sb_q[$];
    string nm_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .Zero(Zero),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ImmSrc(ImmSrc), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Hand-transcribed per-state output table.
    function automatic exp_t mk(input logic [3:0] st, input logic [6:0] o, input logic z, input logic rn);
        exp_t e;
        e = '0;
        e.st = st;
        case (st)
            4'd0:  begin e.irw = 1'b1; e.sb = 2'b10; e.rs = 2'b10; e.pcw = 1'b1; end
            4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
            4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
            4'd3:  begin e.adr = 1'b1; end
            4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            4'd6:  begin e.sa = 2'b10; e.aop = 2'b10; end
            4'd7:  begin e.rw = 1'b1; end
            4'd8:  begin e.sa = 2'b10; e.sb = 2'b01; e.aop = 2'b10; end
            4'd9:  begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
            4'd10: begin e.sa = 2'b10; e.aop = 2'b01; e.pcw = z; end
            default: ;
        endcase
        e.ill = (st == 4'd1) && !(o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ);
        case (o)
            SW:      e.imm = 2'b01;
            BQ:      e.imm = 2'b10;
            JL:      e.imm = 2'b11;
            default: e.imm = 2'b00;
        endcase
        if (!rn) begin
            e.pcw = 1'b0; e.mw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.ill = 1'b0;
        end
        return e;
    endfunction

    task automatic cyc(input logic [6:0] o, input logic z, input logic rn,
                       input logic [3:0] st, input string nm);
        @(posedge clk);
        #1;
        op = o;
        Zero = z;
        rst_n = rn;
        sb_q.push_back(mk(st, o, z, rn));
        nm_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t  e;
        exp_t  a;
        string nm;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e  = sb_q.pop_front();
                nm = nm_q.pop_front();
                a  = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, illegal};
                n_vec++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b sa=%b sb=%b aop=%b imm=%b ill=%b, want st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b sa=%b sb=%b aop=%b imm=%b ill=%b",
                             nm, a.st, a.pcw, a.adr, a.mw, a.irw, a.rw, a.rs, a.sa, a.sb, a.aop, a.imm, a.ill,
                             e.st, e.pcw, e.adr, e.mw, e.irw, e.rw, e.rs, e.sa, e.sb, e.aop, e.imm, e.ill);
                end
            end
        end
    end

    initial begin : stimulus
        repeat (3) cyc(LW, 1'b0, 1'b0, 4'd0, "reset_hold");
        cyc(LW, 1'b0, 1'b1, 4'd0, "lw_fetch");
        cyc(LW, 1'b0, 1'b1, 4'd1, "lw_decode");
        cyc(LW, 1'b0, 1'b1, 4'd2, "lw_memadr");
        cyc(LW, 1'b0, 1'b1, 4'd3, "lw_memread");
        cyc(LW, 1'b0, 1'b1, 4'd4, "lw_memwb");

        cyc(SW, 1'b0, 1'b1, 4'd0, "sw_fetch");
        cyc(SW, 1'b0, 1'b1, 4'd1, "sw_decode");
        cyc(SW, 1'b0, 1'b1, 4'd2, "sw_memadr");
        cyc(SW, 1'b0, 1'b1, 4'd5, "sw_memwrite");

        cyc(RT, 1'b1, 1'b1, 4'd0, "r_fetch");
        cyc(RT, 1'b1, 1'b1, 4'd1, "r_decode");
        cyc(RT, 1'b1, 1'b1, 4'd6, "r_execute");
        cyc(RT, 1'b1, 1'b1, 4'd7, "r_aluwb");

        cyc(IT, 1'b0, 1'b1, 4'd0, "i_fetch");
        cyc(IT, 1'b0, 1'b1, 4'd1, "i_decode");
        cyc(IT, 1'b0, 1'b1, 4'd8, "i_execute");
        cyc(IT, 1'b0, 1'b1, 4'd7, "i_aluwb");

        cyc(JL, 1'b0, 1'b1, 4'd0, "jal_fetch");
        cyc(JL, 1'b0, 1'b1, 4'd1, "jal_decode");
        cyc(JL, 1'b0, 1'b1, 4'd9, "jal_jal");
        cyc(JL, 1'b0, 1'b1, 4'd7, "jal_aluwb");

        cyc(BQ, 1'b1, 1'b1, 4'd0, "beq_taken_fetch");
        cyc(BQ, 1'b1, 1'b1, 4'd1, "beq_taken_decode");
        cyc(BQ, 1'b1, 1'b1, 4'd10, "beq_taken_beq");
        cyc(BQ, 1'b0, 1'b1, 4'd0, "beq_nt_fetch");
        cyc(BQ, 1'b0, 1'b1, 4'd1, "beq_nt_decode");
        cyc(BQ, 1'b0, 1'b1, 4'd10, "beq_nt_beq");

        cyc(BAD, 1'b0, 1'b1, 4'd0, "ill_fetch");
        cyc(BAD, 1'b0, 1'b1, 4'd1, "ill_decode");

        cyc(LW, 1'b0, 1'b1, 4'd0, "lw2_fetch");
        cyc(LW, 1'b0, 1'b1, 4'd1, "lw2_decode");
        cyc(LW, 1'b0, 1'b1, 4'd2, "lw2_memadr");
        cyc(LW, 1'b0, 1'b1, 4'd3, "lw2_memread");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (state_dbg !== 4'd0 || RegWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_memread: got st=%0d rw=%b, want st=0 rw=0", state_dbg, RegWrite);
        end
        cyc(LW, 1'b0, 1'b0, 4'd0, "reset_mid_hold");
        cyc(LW, 1'b0, 1'b1, 4'd0, "after_reset_fetch");
        cyc(LW, 1'b0, 1'b1, 4'd1, "after_reset_decode");

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
